// File: rtl/mult_pkg.sv
// Shared definitions for the multiply-accumulate back end: default widths
// and the block-accumulation state encoding.
package mult_pkg;

   localparam int PROD_W_DEF  = 64;
   localparam int GUARD_W_DEF = 8;
   localparam int CNT_W_DEF   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/mult_accumulator_if.sv
// Product stream in, block-sum result out. The master drives products and
// takes results; the slave is the accumulator.
interface mult_accumulator_if
   import mult_pkg::*;
#(
   parameter int PROD_W  = PROD_W_DEF,
   parameter int GUARD_W = GUARD_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
);
   localparam int ACC_W = PROD_W + GUARD_W;

   logic              clear;
   logic [CNT_W-1:0]  blk_len;
   logic              prod_valid;
   logic              prod_ready;
   logic [PROD_W-1:0] prod_data;
   logic              acc_valid;
   logic              acc_ready;
   logic [ACC_W-1:0]  acc_data;
   logic              acc_ovf;

   modport master (
      output clear, blk_len, prod_valid, prod_data, acc_ready,
      input  prod_ready, acc_valid, acc_data, acc_ovf
   );

   modport slave (
      input  clear, blk_len, prod_valid, prod_data, acc_ready,
      output prod_ready, acc_valid, acc_data, acc_ovf
   );

endinterface

// File: rtl/mac_adder.sv
// Combinational accumulator adder with carry-out. Kept as its own block so a
// ripple or carry-lookahead implementation can replace it without touching
// the control logic.
module mac_adder #(
   parameter int W = 72
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o,
   output logic         carry_o
);

   assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/mult_accumulator.sv
// Sums blocks of unsigned multiplier products into a guarded accumulator and
// hands each block sum, with a sticky wrap flag, to a downstream consumer.
module mult_accumulator
   import mult_pkg::*;
#(
   parameter int PROD_W  = PROD_W_DEF,
   parameter int GUARD_W = GUARD_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   mult_accumulator_if.slave bus
);

   localparam int ACC_W = PROD_W + GUARD_W;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               prod_ready_q, prod_ready_d;
   logic               acc_valid_q, acc_valid_d;

   logic               prod_acc;
   logic               res_acc;
   logic [CNT_W-1:0]   blk_n;
   logic [ACC_W-1:0]   add_sum;
   logic               add_carry;

   assign prod_acc = bus.prod_valid & prod_ready_q;
   assign res_acc  = acc_valid_q & bus.acc_ready;
   // A zero block length is treated as a single-product block.
   assign blk_n    = (bus.blk_len == '0) ? CNT_W'(1) : bus.blk_len;

   mac_adder #(
      .W (ACC_W)
   ) u_adder (
      .a_i     (acc_q),
      .b_i     (ACC_W'(bus.prod_data)),
      .sum_o   (add_sum),
      .carry_o (add_carry)
   );

   // Next-state and datapath update; clear overrides every state.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (bus.clear) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (prod_acc) begin
                  acc_d   = ACC_W'(bus.prod_data);
                  ovf_d   = 1'b0;
                  cnt_d   = blk_n - CNT_W'(1);
                  state_d = (blk_n == CNT_W'(1)) ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (prod_acc) begin
                  acc_d = add_sum;
                  ovf_d = ovf_q | add_carry;
                  cnt_d = cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) state_d = DONE;
               end
            end
            DONE: begin
               // The cycle that hands off the result never accepts a product.
               if (res_acc) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      prod_ready_d = (state_d != DONE);
      acc_valid_d  = (state_d == DONE);
   end

   // State, accumulator and handshake registers; outputs come straight from here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         prod_ready_q <= 1'b0;
         acc_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         prod_ready_q <= prod_ready_d;
         acc_valid_q  <= acc_valid_d;
      end
   end

   assign bus.prod_ready = prod_ready_q;
   assign bus.acc_valid  = acc_valid_q;
   assign bus.acc_data   = acc_q;
   assign bus.acc_ovf    = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Bench for mult_accumulator: two instances (8 guard bits and no guard bits)
// share one stimulus stream; block sums are predicted from the plain
// arithmetic sum of the accepted products.
module tb_mult_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clear = 1'b0;
   logic [7:0]  blk_len = 8'd0;
   logic        prod_valid = 1'b0;
   logic [63:0] prod_data = 64'd0;
   logic        acc_ready = 1'b0;

   always #5 clk = ~clk;

   mult_accumulator_if #(.PROD_W(64), .GUARD_W(8), .CNT_W(8)) if8 ();
   mult_accumulator_if #(.PROD_W(64), .GUARD_W(0), .CNT_W(8)) if0 ();

   assign if8.clear      = clear;
   assign if8.blk_len    = blk_len;
   assign if8.prod_valid = prod_valid;
   assign if8.prod_data  = prod_data;
   assign if8.acc_ready  = acc_ready;
   assign if0.clear      = clear;
   assign if0.blk_len    = blk_len;
   assign if0.prod_valid = prod_valid;
   assign if0.prod_data  = prod_data;
   assign if0.acc_ready  = acc_ready;

   mult_accumulator #(.PROD_W(64), .GUARD_W(8), .CNT_W(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if8)
   );

   mult_accumulator #(.PROD_W(64), .GUARD_W(0), .CNT_W(8)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference: exact (unwrapped) block sum and products still owed.
   logic [79:0] m_sum  = 80'd0;
   int          m_left = 0;
   bit          m_done = 1'b0;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Full output comparison for both instances against an exact sum s.
   task automatic check_outs(input string tag, input logic vld, input logic rdy, input logic [79:0] s);
      check({tag, "_vld8"}, 80'(if8.acc_valid),  80'(vld));
      check({tag, "_vld0"}, 80'(if0.acc_valid),  80'(vld));
      check({tag, "_rdy8"}, 80'(if8.prod_ready), 80'(rdy));
      check({tag, "_rdy0"}, 80'(if0.prod_ready), 80'(rdy));
      check({tag, "_dat8"}, 80'(if8.acc_data),   80'(s[71:0]));
      check({tag, "_ovf8"}, 80'(if8.acc_ovf),    80'(|s[79:72]));
      check({tag, "_dat0"}, 80'(if0.acc_data),   80'(s[63:0]));
      check({tag, "_ovf0"}, 80'(if0.acc_ovf),    80'(|s[79:64]));
   endtask

   task automatic model_accept(input logic [63:0] d, input logic [7:0] len);
      if (m_left == 0) begin
         m_left = (len == 8'd0) ? 1 : int'(len);
         m_sum  = 80'd0;
      end
      m_sum  = m_sum + 80'(d);
      m_left = m_left - 1;
      m_done = (m_left == 0);
   endtask

   task automatic model_clear();
      m_left = 0;
      m_done = 1'b0;
      m_sum  = 80'd0;
   endtask

   function automatic logic [63:0] rnd_prod();
      logic [63:0] v;
      case ($urandom_range(0, 3))
         0:       v = 64'($urandom_range(0, 255));
         1:       v = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   // Offer one product after `gap` idle cycles; entered and left on a negedge.
   task automatic put_prod(input logic [63:0] d, input logic [7:0] len, input int gap);
      int guard = 0;
      for (int i = 0; i < gap; i++) begin
         prod_valid = 1'b0;
         prod_data  = {$urandom, $urandom};
         @(negedge clk);
      end
      prod_valid = 1'b1;
      prod_data  = d;
      blk_len    = len;
      while (!if8.prod_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("prod_ready_wait", 80'(guard < 50), 80'd1);
      @(negedge clk);
      prod_valid = 1'b0;
      blk_len    = 8'($urandom);
      model_accept(d, len);
      if (m_done) check_outs("last", 1'b1, 1'b0, m_sum);
      else begin
         check("mid_vld8", 80'(if8.acc_valid), 80'd0);
         check("mid_rdy0", 80'(if0.prod_ready), 80'd1);
      end
   endtask

   // Hold the result for `stall` cycles (products offered meanwhile), then take it.
   task automatic take_result(input int stall);
      logic [79:0] s;
      s = m_sum;
      for (int i = 0; i < stall; i++) begin
         acc_ready  = 1'b0;
         prod_valid = 1'($urandom_range(0, 1));
         prod_data  = {$urandom, $urandom};
         @(negedge clk);
         check_outs("hold", 1'b1, 1'b0, s);
      end
      prod_valid = 1'b0;
      acc_ready  = 1'b1;
      @(negedge clk);
      acc_ready = 1'b0;
      check("taken_vld8", 80'(if8.acc_valid),  80'd0);
      check("taken_vld0", 80'(if0.acc_valid),  80'd0);
      check("taken_rdy8", 80'(if8.prod_ready), 80'd1);
      m_done = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      logic [7:0] len;

      #1 rst_n = 1'b0;
      @(negedge clk);
      check_outs("rst0", 1'b0, 1'b0, 80'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_outs("rel0", 1'b0, 1'b0, 80'd0);
      @(negedge clk);
      check_outs("rel1", 1'b0, 1'b1, 80'd0);

      // Single-product block.
      put_prod(64'h0000_0001_0000_0002, 8'd1, 0);
      take_result(0);

      // Four products with gaps; later blk_len values are ignored.
      put_prod(64'd10, 8'd4, 1);
      put_prod(64'd20, 8'd9, 2);
      put_prod(64'd30, 8'd1, 0);
      put_prod(64'd40, 8'd0, 3);
      take_result(3);

      // Zero length acts as one.
      put_prod(64'd7, 8'd0, 0);
      take_result(0);

      // Wrap in the unguarded instance, then a clean block.
      put_prod(64'hFFFF_FFFF_FFFF_FFFF, 8'd2, 0);
      put_prod(64'd2, 8'd5, 0);
      take_result(1);
      put_prod(64'd5, 8'd1, 0);
      take_result(0);

      // Long back-pressure on the result.
      put_prod(64'd123, 8'd1, 0);
      take_result(10);

      // Clear mid-block with a product on offer and the wrap flag already set.
      put_prod(64'hFFFF_FFFF_FFFF_FFFF, 8'd4, 0);
      put_prod(64'hFFFF_FFFF_FFFF_FFFF, 8'd4, 0);
      check("ovf_sticky_mid", 80'(if0.acc_ovf), 80'd1);
      clear      = 1'b1;
      prod_valid = 1'b1;
      prod_data  = 64'd99;
      @(negedge clk);
      clear      = 1'b0;
      prod_valid = 1'b0;
      model_clear();
      check_outs("clr", 1'b0, 1'b1, 80'd0);
      put_prod(64'd9, 8'd1, 0);
      take_result(0);

      // Asynchronous reset in the middle of a block.
      put_prod(64'd3, 8'd4, 0);
      put_prod(64'd4, 8'd4, 0);
      #2 rst_n = 1'b0;
      #1 check_outs("arst", 1'b0, 1'b0, 80'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      @(negedge clk);
      check_outs("arst_rel", 1'b0, 1'b1, 80'd0);

      // Randomized blocks.
      for (int b = 0; b < 25; b++) begin
         len = 8'($urandom_range(0, 5));
         n   = (len == 8'd0) ? 1 : int'(len);
         for (int k = 0; k < n; k++) begin
            put_prod(rnd_prod(), (k == 0) ? len : 8'($urandom), $urandom_range(0, 2));
         end
         take_result($urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
